// File: rtl/olivia_sequencer.sv
// Multi-cycle control sequencer for a small LEGv8 subset (R-type, LDUR, STUR, CBZ, B).
// Outputs decode from the registered state and latched class; only DECODE looks at opcode.
module olivia_sequencer #(
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic [10:0]      opcode,
    input  logic             zero_flag,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_we,
    output logic             mem_addr_sel,
    output logic             ir_write,
    output logic             pc_write,
    output logic [1:0]       pc_src,
    output logic             reg2loc,
    output logic             alu_src,
    output logic [1:0]       alu_op,
    output logic             mem2reg,
    output logic             reg_write,
    output logic             halted,
    output logic [1:0]       err_code,
    output logic [CNT_W-1:0] retired,
    output logic [2:0]       fsm_state
);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
    } state_t;

    typedef enum logic [2:0] {
        C_NONE, C_RTYPE, C_LDUR, C_STUR, C_CBZ, C_B
    } cls_t;

    localparam logic [15:0] WAIT_LAST = 16'(MEM_TIMEOUT - 1);

    state_t      state;
    cls_t        cls;
    cls_t        dec_cls;
    logic [15:0] wait_cnt;
    logic [1:0]  err_q;
    logic        retire;

    assign fsm_state = state;
    assign err_code  = err_q;
    assign halted    = (state == S_HALT);

    always_comb begin
        dec_cls = C_NONE;
        casez (opcode)
            11'b10001011000,
            11'b11001011000,
            11'b10001010000,
            11'b10101010000: dec_cls = C_RTYPE;
            11'b11111000010: dec_cls = C_LDUR;
            11'b11111000000: dec_cls = C_STUR;
            11'b10110100???: dec_cls = C_CBZ;
            11'b000101?????: dec_cls = C_B;
            default:         dec_cls = C_NONE;
        endcase
    end

    always_comb begin
        retire = 1'b0;
        case (state)
            S_DECODE: retire = (dec_cls == C_B);
            S_EXEC:   retire = (cls == C_CBZ);
            S_MEM:    retire = (cls == C_STUR) && mem_ready;
            S_WB:     retire = 1'b1;
            default:  retire = 1'b0;
        endcase
    end

    // Memory handshake: mem_req is held while in FETCH/MEM; a transfer completes in the
    // cycle mem_req=1 and mem_ready=1, and mem_ready is ignored whenever mem_req=0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_IDLE;
            cls      <= C_NONE;
            wait_cnt <= '0;
            err_q    <= 2'd0;
            retired  <= '0;
        end else begin
            if (retire) begin
                retired  <= retired + 1'b1;
                state    <= run ? S_FETCH : S_IDLE;
                wait_cnt <= '0;
            end
            case (state)
                S_IDLE: begin
                    if (run) begin
                        state    <= S_FETCH;
                        wait_cnt <= '0;
                    end
                end
                S_FETCH: begin
                    if (mem_ready) begin
                        state <= S_DECODE;
                    end else if (wait_cnt == WAIT_LAST) begin
                        state <= S_HALT;
                        err_q <= 2'd2;
                    end else begin
                        wait_cnt <= wait_cnt + 16'd1;
                    end
                end
                S_DECODE: begin
                    cls <= dec_cls;
                    if (dec_cls == C_NONE) begin
                        state <= S_HALT;
                        err_q <= 2'd1;
                    end else if (dec_cls != C_B) begin
                        state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    case (cls)
                        C_RTYPE: state <= S_WB;
                        C_LDUR, C_STUR: begin
                            state    <= S_MEM;
                            wait_cnt <= '0;
                        end
                        default: ;
                    endcase
                end
                S_MEM: begin
                    if (mem_ready) begin
                        if (cls == C_LDUR) state <= S_WB;
                    end else if (wait_cnt == WAIT_LAST) begin
                        state <= S_HALT;
                        err_q <= 2'd2;
                    end else begin
                        wait_cnt <= wait_cnt + 16'd1;
                    end
                end
                S_WB:    ;
                S_HALT:  state <= S_HALT;
                default: state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr_sel = 1'b0;
        ir_write     = 1'b0;
        pc_write     = 1'b0;
        pc_src       = 2'd0;
        reg2loc      = 1'b0;
        alu_src      = 1'b0;
        alu_op       = 2'b00;
        mem2reg      = 1'b0;
        reg_write    = 1'b0;
        case (state)
            S_FETCH: begin
                mem_req  = 1'b1;
                ir_write = mem_ready;
                pc_write = mem_ready;
            end
            S_DECODE: begin
                if (dec_cls == C_B) begin
                    pc_write = 1'b1;
                    pc_src   = 2'd2;
                end
            end
            S_EXEC: begin
                case (cls)
                    C_RTYPE: alu_op = 2'b10;
                    C_LDUR, C_STUR: begin
                        alu_src = 1'b1;
                        reg2loc = 1'b1;
                    end
                    C_CBZ: begin
                        alu_op   = 2'b01;
                        reg2loc  = 1'b1;
                        pc_write = zero_flag;
                        pc_src   = 2'd1;
                    end
                    default: ;
                endcase
            end
            S_MEM: begin
                mem_req      = 1'b1;
                mem_addr_sel = 1'b1;
                mem_we       = (cls == C_STUR);
                alu_src      = 1'b1;
                reg2loc      = 1'b1;
            end
            S_WB: begin
                // ALU controls stay as in EXEC so the writeback source remains stable
                reg_write = 1'b1;
                mem2reg   = (cls == C_LDUR);
                if (cls == C_RTYPE) begin
                    alu_op = 2'b10;
                end else begin
                    alu_src = 1'b1;
                    reg2loc = 1'b1;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_olivia_sequencer.sv
// Bench for olivia_sequencer: per-instruction expected traces planned from the
// instruction rules, replayed cycle by cycle against the DUT outputs.
module tb_olivia_sequencer;

    localparam int CNT_W = 4;
    localparam int TMO   = 4;

    localparam logic [10:0] OP_ADD  = 11'b10001011000;
    localparam logic [10:0] OP_SUB  = 11'b11001011000;
    localparam logic [10:0] OP_AND  = 11'b10001010000;
    localparam logic [10:0] OP_ORR  = 11'b10101010000;
    localparam logic [10:0] OP_LDUR = 11'b11111000010;
    localparam logic [10:0] OP_STUR = 11'b11111000000;
    localparam logic [15:0] ALL     = 16'hFFFF;
    localparam logic [15:0] NO_ALU  = 16'hFE1F;

    logic             clk = 1'b0;
    logic             rst, run, zero_flag, mem_ready;
    logic [10:0]      opcode;
    logic             mem_req, mem_we, mem_addr_sel, ir_write, pc_write;
    logic [1:0]       pc_src, alu_op, err_code;
    logic             reg2loc, alu_src, mem2reg, reg_write, halted;
    logic [CNT_W-1:0] retired;
    logic [2:0]       fsm_state;
    logic [15:0]      ctl;

    int checks   = 0;
    int failures = 0;
    logic [CNT_W-1:0] model_retired;

    logic [15:0] exp_q[$];
    logic [15:0] msk_q[$];
    logic [10:0] op_q[$];
    logic        rdy_q[$];
    logic        run_q[$];
    logic        ret_q[$];

    olivia_sequencer #(.MEM_TIMEOUT(TMO), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .run(run), .opcode(opcode), .zero_flag(zero_flag),
        .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr_sel(mem_addr_sel), .ir_write(ir_write), .pc_write(pc_write),
        .pc_src(pc_src), .reg2loc(reg2loc), .alu_src(alu_src), .alu_op(alu_op),
        .mem2reg(mem2reg), .reg_write(reg_write), .halted(halted),
        .err_code(err_code), .retired(retired), .fsm_state(fsm_state)
    );

    always #5 clk = ~clk;

    assign ctl = {mem_req, mem_we, mem_addr_sel, ir_write, pc_write, pc_src,
                  reg2loc, alu_src, alu_op, mem2reg, reg_write, halted, err_code};

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] ctl_v(
        input logic req, input logic we, input logic asel, input logic irw,
        input logic pcw, input logic [1:0] psrc, input logic r2l, input logic asrc,
        input logic [1:0] aop, input logic m2r, input logic rw, input logic hlt,
        input logic [1:0] err);
        return {req, we, asel, irw, pcw, psrc, r2l, asrc, aop, m2r, rw, hlt, err};
    endfunction

    function automatic logic rnd_bit();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic [10:0] rnd_op();
        return 11'($urandom_range(0, 2047));
    endfunction

    // 0 illegal, 1 R-type, 2 LDUR, 3 STUR, 4 CBZ, 5 B
    function automatic int classify(input logic [10:0] op);
        if (op == OP_ADD || op == OP_SUB || op == OP_AND || op == OP_ORR) return 1;
        if (op == OP_LDUR) return 2;
        if (op == OP_STUR) return 3;
        if (op ==? 11'b10110100???) return 4;
        if (op ==? 11'b000101?????) return 5;
        return 0;
    endfunction

    function automatic logic [10:0] rnd_legal_op();
        logic [10:0] rt_ops[4];
        rt_ops = '{OP_ADD, OP_SUB, OP_AND, OP_ORR};
        case ($urandom_range(1, 5))
            1:       return rt_ops[$urandom_range(0, 3)];
            2:       return OP_LDUR;
            3:       return OP_STUR;
            4:       return {8'b10110100, 3'($urandom_range(0, 7))};
            default: return {6'b000101, 5'($urandom_range(0, 31))};
        endcase
    endfunction

    task automatic push(input logic [15:0] e, input logic [15:0] m, input logic [10:0] op,
                        input logic rdy, input logic r, input logic ret);
        exp_q.push_back(e);
        msk_q.push_back(m);
        op_q.push_back(op);
        rdy_q.push_back(rdy);
        run_q.push_back(r);
        ret_q.push_back(ret);
    endtask

    task automatic plan_idle_start();
        push(16'h0, ALL, rnd_op(), rnd_bit(), 1'b0, 1'b0);
        push(16'h0, ALL, rnd_op(), rnd_bit(), 1'b1, 1'b0);
    endtask

    task automatic plan_halt(input logic [1:0] err, input int n);
        for (int i = 0; i < n; i++)
            push(ctl_v(0,0,0,0,0,2'd0,0,0,2'd0,0,0,1,err), ALL, rnd_op(), rnd_bit(), rnd_bit(), 1'b0);
    endtask

    task automatic plan_after_retire(input logic run_next);
        if (!run_next) plan_idle_start();
    endtask

    // Waits >= TMO mean mem_ready never arrives and the access times out.
    task automatic plan_instr(input logic [10:0] op, input int fwait, input int mwait,
                              input logic zf, input logic run_next);
        int c;
        int n;
        logic rdy;
        c = classify(op);
        n = (fwait >= TMO) ? TMO : fwait + 1;
        for (int k = 0; k < n; k++) begin
            rdy = (k == fwait);
            push(ctl_v(1,0,0,rdy,rdy,2'd0,0,0,2'd0,0,0,0,2'd0), ALL, rnd_op(), rdy, rnd_bit(), 1'b0);
        end
        if (fwait >= TMO) begin
            plan_halt(2'd2, 3);
            return;
        end
        if (c == 5) begin
            push(ctl_v(0,0,0,0,1,2'd2,0,0,2'd0,0,0,0,2'd0), ALL, op, rnd_bit(), run_next, 1'b1);
            plan_after_retire(run_next);
            return;
        end
        push(16'h0, ALL, op, rnd_bit(), rnd_bit(), 1'b0);
        if (c == 0) begin
            plan_halt(2'd1, 4);
            return;
        end
        if (c == 1) begin
            push(ctl_v(0,0,0,0,0,2'd0,0,0,2'b10,0,0,0,2'd0), ALL, rnd_op(), rnd_bit(), rnd_bit(), 1'b0);
        end else if (c == 4) begin
            push(ctl_v(0,0,0,0,zf,2'd1,1,0,2'b01,0,0,0,2'd0), ALL, rnd_op(), rnd_bit(), run_next, 1'b1);
            plan_after_retire(run_next);
            return;
        end else begin
            push(ctl_v(0,0,0,0,0,2'd0,1,1,2'b00,0,0,0,2'd0), ALL, rnd_op(), rnd_bit(), rnd_bit(), 1'b0);
            n = (mwait >= TMO) ? TMO : mwait + 1;
            for (int k = 0; k < n; k++) begin
                rdy = (k == mwait);
                push(ctl_v(1,(c == 3),1,0,0,2'd0,1,1,2'b00,0,0,0,2'd0), ALL, rnd_op(), rdy,
                     (c == 3 && rdy) ? run_next : rnd_bit(), (c == 3 && rdy));
            end
            if (mwait >= TMO) begin
                plan_halt(2'd2, 3);
                return;
            end
            if (c == 3) begin
                plan_after_retire(run_next);
                return;
            end
        end
        push(ctl_v(0,0,0,0,0,2'd0,0,0,2'd0,(c == 2),1,0,2'd0), NO_ALU, rnd_op(), rnd_bit(), run_next, 1'b1);
        plan_after_retire(run_next);
    endtask

    task automatic play(input string tag);
        while (exp_q.size() > 0) begin
            logic [15:0] e;
            logic [15:0] m;
            logic        ret;
            e         = exp_q.pop_front();
            m         = msk_q.pop_front();
            opcode    = op_q.pop_front();
            mem_ready = rdy_q.pop_front();
            run       = run_q.pop_front();
            ret       = ret_q.pop_front();
            @(negedge clk);
            check_eq({tag, "_ctl"}, 32'(ctl & m), 32'(e));
            check_eq({tag, "_retired"}, 32'(retired), 32'(model_retired));
            @(posedge clk);
            #1;
            if (ret) model_retired = model_retired + 1'b1;
        end
    endtask

    task automatic run_instr(input string tag, input logic [10:0] op, input int fwait,
                             input int mwait, input logic zf, input logic run_next);
        zero_flag = zf;
        plan_instr(op, fwait, mwait, zf, run_next);
        play(tag);
    endtask

    // Reset is asserted between clock edges to show it acts asynchronously.
    task automatic do_reset(input string tag);
        #2 rst = 1'b0;
        #1;
        check_eq({tag, "_mem_req"}, 32'(mem_req), 32'd0);
        check_eq({tag, "_ctl"}, 32'(ctl), 32'd0);
        check_eq({tag, "_retired"}, 32'(retired), 32'd0);
        model_retired = '0;
        run       = 1'b1;
        mem_ready = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        check_eq({tag, "_held_ctl"}, 32'(ctl), 32'd0);
        rst       = 1'b1;
        run       = 1'b0;
        mem_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [10:0] op;
        rst           = 1'b0;
        run           = 1'b0;
        opcode        = '0;
        zero_flag     = 1'b0;
        mem_ready     = 1'b0;
        model_retired = '0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("reset_ctl", 32'(ctl), 32'd0);
        check_eq("reset_retired", 32'(retired), 32'd0);
        rst = 1'b1;
        plan_idle_start();
        play("idle");

        run_instr("add",      OP_ADD,  0, 0, 1'b0, 1'b1);
        run_instr("ldur_w3",  OP_LDUR, 0, 3, 1'b0, 1'b1);
        run_instr("cbz_taken", 11'b10110100101, 1, 0, 1'b1, 1'b1);
        run_instr("cbz_not",  11'b10110100010, 0, 0, 1'b0, 1'b1);
        run_instr("stur",     OP_STUR, 2, 1, 1'b0, 1'b1);
        run_instr("sub",      OP_SUB,  0, 0, 1'b1, 1'b0);
        run_instr("and",      OP_AND,  3, 0, 1'b0, 1'b1);
        run_instr("orr",      OP_ORR,  0, 0, 1'b0, 1'b0);
        run_instr("b",        11'b00010111111, 1, 0, 1'b0, 1'b0);

        for (int i = 0; i < 40; i++)
            run_instr("rand", rnd_legal_op(), $urandom_range(0, TMO - 1),
                      $urandom_range(0, TMO - 1), rnd_bit(), ($urandom_range(0, 3) != 0));

        do_reset("rst_pre_wrap");
        plan_idle_start();
        play("idle_wrap");
        for (int i = 0; i < 17; i++)
            run_instr("b_wrap", {6'b000101, 5'($urandom_range(0, 31))},
                      $urandom_range(0, TMO - 1), 0, rnd_bit(), 1'b1);
        check_eq("wrap_retired", 32'(retired), 32'd1);
        push(ctl_v(1,0,0,0,0,2'd0,0,0,2'd0,0,0,0,2'd0), ALL, rnd_op(), 1'b0, rnd_bit(), 1'b0);
        push(ctl_v(1,0,0,0,0,2'd0,0,0,2'd0,0,0,0,2'd0), ALL, rnd_op(), 1'b0, rnd_bit(), 1'b0);
        play("fetch_hold");
        do_reset("rst_mid_fetch");

        plan_idle_start();
        run_instr("illegal_ones", 11'b11111111111, 0, 0, 1'b0, 1'b1);
        do_reset("rst_after_ill");

        do op = rnd_op(); while (classify(op) != 0);
        plan_idle_start();
        run_instr("illegal_rand", op, 1, 0, 1'b0, 1'b1);
        do_reset("rst_after_ill2");

        plan_idle_start();
        run_instr("fetch_timeout", OP_ADD, TMO, 0, 1'b0, 1'b1);
        do_reset("rst_after_fto");

        plan_idle_start();
        run_instr("mem_timeout", OP_LDUR, 0, TMO, 1'b0, 1'b1);
        do_reset("rst_after_mto");

        plan_idle_start();
        run_instr("post_reset_add", OP_ADD, 0, 0, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/olivia_sequencer.md
OLIVIA_SEQUENCER -- requirements
Module: olivia_sequencer

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 255, max cycles a memory request may wait for mem_ready before fault (1..65535).
REQ-002 SHALL have parameter CNT_W, default 32, width of retired-instruction counter.
REQ-003 SHALL have ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- run  in  1  permits starting a new instruction.
- opcode  in  11  instruction[31:21] from instruction register.
- zero_flag  in  1  ALU zero result.
- mem_ready  in  1  memory completion strobe.
- mem_req  out  1  memory access request.
- mem_we  out  1  write qualifier for mem_req.
- mem_addr_sel  out  1  0 = PC (fetch), 1 = ALU result (data).
- ir_write  out  1  load instruction register.
- pc_write  out  1  update PC.
- pc_src  out  2  0 = PC+4, 1 = CBZ target, 2 = B target.
- reg2loc  out  1  1 selects rt as second read register.
- alu_src  out  1  1 selects sign-extended immediate.
- alu_op  out  2  00 add (LDUR/STUR), 01 pass-B (CBZ), 10 R-type.
- mem2reg  out  1  1 selects memory data for writeback.
- reg_write  out  1  register file write enable.
- halted  out  1  sequencer in HALT.
- err_code  out  2  0 none, 1 illegal opcode, 2 memory timeout.
- retired  out  CNT_W  retired-instruction count.

Function
REQ-004 SHALL implement states IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT; outputs decoded from registered state and latched class (Moore), no combinational path from opcode to outputs except in DECODE.
REQ-005 IDLE: all enables 0; go FETCH when run=1, else stay.
REQ-006 FETCH: mem_req=1, mem_we=0, mem_addr_sel=0; on mem_ready=1 same cycle ir_write=1, pc_write=1, pc_src=0, next DECODE; else hold.
REQ-007 DECODE: classify opcode: ADD 10001011000, SUB 11001011000, AND 10001010000, ORR 10101010000 = RTYPE; 11111000010 = LDUR; 11111000000 = STUR; 10110100xxx = CBZ; 000101xxxxx = B; latch class.
REQ-008 DECODE: B -> pc_write=1, pc_src=2, retire; unlisted opcode -> HALT, err_code=1; else -> EXEC.
REQ-009 EXEC: RTYPE alu_op=10, alu_src=0, reg2loc=0 -> WB; LDUR/STUR alu_op=00, alu_src=1, reg2loc=1 -> MEM; CBZ alu_op=01, reg2loc=1, pc_write=zero_flag, pc_src=1, retire.
REQ-010 MEM: mem_req=1, mem_addr_sel=1, mem_we=1 for STUR else 0, ALU controls held as EXEC; on mem_ready: STUR retires, LDUR -> WB.
REQ-011 WB: reg_write=1 exactly one cycle; mem2reg=1 for LDUR, 0 for RTYPE; retire.
REQ-012 Retire SHALL increment retired by 1 (wraps at 2^CNT_W-1 -> 0) and go FETCH if run=1, else IDLE.
REQ-013 run sampled only in IDLE and at retire; deasserting run mid-instruction SHALL NOT abort it.
REQ-014 mem_req SHALL stay high until mem_ready sampled high, then drop next cycle unless new access begins; mem_ready while mem_req=0 ignored.
REQ-015 Wait counter cleared on entry to FETCH/MEM, increments each cycle mem_ready=0; reaching MEM_TIMEOUT -> HALT, err_code=2, mem_req=0 next cycle.
REQ-016 HALT: all enables 0, halted=1, err_code held; exit only via reset.
REQ-017 Latency without wait: RTYPE/LDUR 4/5 cycles (FETCH..WB), STUR 4, CBZ 3, B 2.

Reset
REQ-018 rst=0 SHALL asynchronously force IDLE, all outputs 0, retired=0, err_code=0, wait counter 0, class cleared.
REQ-019 Reset mid-access SHALL drop mem_req immediately; first request after release only after run=1 in IDLE.

Verification
REQ-020 run=1, ADD, zero-wait memory -> FETCH,DECODE,EXEC,WB; reg_write one cycle, retired 0->1.
REQ-021 LDUR, mem_ready delayed 3 cycles in MEM -> mem_req high 4 cycles with mem_addr_sel=1, then WB with mem2reg=1.
REQ-022 CBZ with zero_flag=1 then 0 -> pc_write=1/pc_src=1 first, pc_write=0 second; both retire.
REQ-023 opcode 11111111111 -> HALT, halted=1, err_code=1; further run/mem_ready ignored until rst=0.
REQ-024 MEM_TIMEOUT=4, mem_ready held 0 in FETCH -> HALT after 4 waiting cycles, err_code=2.
REQ-025 CNT_W=4, 17 B instructions -> retired wraps to 1; rst=0 mid-FETCH -> mem_req 0 immediately, retired=0.
